// File: rtl/button_pkg.sv
// Shared types for the push-button receive path: debounce FSM states and
// synchronizer depth.
package button_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_HELD,
    ST_LONG_HELD,
    ST_RELEASE_WAIT
  } btn_state_t;

endpackage

// File: rtl/button_debounce_sync_2ff.sv
// Generic single-bit synchronizer for asynchronous pin inputs; the reset value
// is a parameter so the chain can idle at the pin's inactive level.
module sync_2ff
  import button_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= {SYNC_STAGES{RESET_VAL}};
    else        sr <= {sr[SYNC_STAGES-2:0], d};
  end

  assign q = sr[SYNC_STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Debounces a raw push-button pin into a clean level plus press/release/long
// pulses. Auto-repeat pulses are built only with BUTTON_DEBOUNCE_REPEAT_EN.
module button_debounce
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int LONG_PRESS_CYCLES = 1000,
  parameter bit ACTIVE_LOW        = 1'b0,
  parameter int REPEAT_CYCLES     = 200
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic BUT,
  output logic PRESSED,
  output logic PRESS,
  output logic RELEASE,
  output logic LONG,
  output logic REPEAT
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  logic raw_sync, s;

  sync_2ff #(.RESET_VAL(ACTIVE_LOW)) u_sync (
    .clk  (CLK),
    .rst_n(RST_N),
    .d    (BUT),
    .q    (raw_sync)
  );

  assign s = ACTIVE_LOW ? ~raw_sync : raw_sync;

  btn_state_t        state, nxt_state;
  logic [CNT_W-1:0]  cnt, nxt_cnt;
  logic [HOLD_W-1:0] hold, nxt_hold;
  logic              long_flag, nxt_long_flag;
  logic              nxt_press, nxt_release, nxt_long, nxt_pressed, rep_clr;

  always_comb begin
    nxt_state     = state;
    nxt_cnt       = cnt;
    nxt_hold      = hold;
    nxt_long_flag = long_flag;
    nxt_press     = 1'b0;
    nxt_release   = 1'b0;
    nxt_long      = 1'b0;
    rep_clr       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s) begin
          nxt_state = ST_PRESS_WAIT;
          nxt_cnt   = CNT_W'(1);
        end
      end
      ST_PRESS_WAIT: begin
        if (!s) nxt_state = ST_IDLE;
        else if (cnt == CNT_LAST) begin
          nxt_state = ST_HELD;
          nxt_press = 1'b1;
          nxt_hold  = '0;
        end else nxt_cnt = cnt + CNT_W'(1);
      end
      ST_HELD: begin
        if (!s) begin
          nxt_state     = ST_RELEASE_WAIT;
          nxt_cnt       = CNT_W'(1);
          nxt_long_flag = 1'b0;
        end else if (hold >= HOLD_LAST) begin
          nxt_state = ST_LONG_HELD;
          nxt_long  = 1'b1;
          rep_clr   = 1'b1;
        end else nxt_hold = hold + HOLD_W'(1);
      end
      ST_LONG_HELD: begin
        if (!s) begin
          nxt_state     = ST_RELEASE_WAIT;
          nxt_cnt       = CNT_W'(1);
          nxt_long_flag = 1'b1;
        end
      end
      ST_RELEASE_WAIT: begin
        if (s) begin
          // release bounce: resume the hold, counting this cycle as held
          nxt_state = long_flag ? ST_LONG_HELD : ST_HELD;
          if (!long_flag && hold < HOLD_LAST) nxt_hold = hold + HOLD_W'(1);
        end else if (cnt == CNT_LAST) begin
          nxt_state   = ST_IDLE;
          nxt_release = 1'b1;
        end else nxt_cnt = cnt + CNT_W'(1);
      end
      default: nxt_state = ST_IDLE;
    endcase
    nxt_pressed = (nxt_state == ST_HELD) || (nxt_state == ST_LONG_HELD) ||
                  (nxt_state == ST_RELEASE_WAIT);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      hold      <= '0;
      long_flag <= 1'b0;
      PRESSED   <= 1'b0;
      PRESS     <= 1'b0;
      RELEASE   <= 1'b0;
      LONG      <= 1'b0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      hold      <= nxt_hold;
      long_flag <= nxt_long_flag;
      PRESSED   <= nxt_pressed;
      PRESS     <= nxt_press;
      RELEASE   <= nxt_release;
      LONG      <= nxt_long;
    end
  end

`ifdef BUTTON_DEBOUNCE_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep, nxt_rep;
  logic             nxt_repeat;

  // counts only while staying in LONG_HELD, so it freezes across release bounce
  always_comb begin
    nxt_rep    = rep;
    nxt_repeat = 1'b0;
    if (rep_clr) nxt_rep = '0;
    else if (state == ST_LONG_HELD && nxt_state == ST_LONG_HELD) begin
      if (rep == REP_LAST) begin
        nxt_rep    = '0;
        nxt_repeat = 1'b1;
      end else nxt_rep = rep + REP_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rep    <= '0;
      REPEAT <= 1'b0;
    end else begin
      rep    <= nxt_rep;
      REPEAT <= nxt_repeat;
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = rep_clr ^ (^REPEAT_CYCLES);
  assign REPEAT = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce: DUT a is active-high, DUT b active-low
// with a short repeat period.
module tb_button_debounce;

  logic CLK = 1'b0, RST_N = 1'b0, but_a = 1'b0, but_b = 1'b1;
  logic pressed_a, press_a, rel_a, long_a, rep_a;
  logic pressed_b, press_b, rel_b, long_b, rep_b;

  int tests = 0, fails = 0, cyc = 0, excl_bad = 0;
  int n_press[2], at_press[2], n_rel[2], at_rel[2];
  int n_long[2], at_long[2], n_rep[2], at_rep[2];

  button_debounce #(.DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(20), .ACTIVE_LOW(1'b0)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .BUT(but_a), .PRESSED(pressed_a), .PRESS(press_a),
    .RELEASE(rel_a), .LONG(long_a), .REPEAT(rep_a));

  button_debounce #(.DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(20), .ACTIVE_LOW(1'b1),
                    .REPEAT_CYCLES(5)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .BUT(but_b), .PRESSED(pressed_b), .PRESS(press_b),
    .RELEASE(rel_b), .LONG(long_b), .REPEAT(rep_b));

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // pulse recorder: cyc equals the index of the edge that produced the pulse
  always @(posedge CLK) begin
    #1;
    if (press_a) begin n_press[0]++; at_press[0] = cyc; end
    if (rel_a)   begin n_rel[0]++;   at_rel[0]   = cyc; end
    if (long_a)  begin n_long[0]++;  at_long[0]  = cyc; end
    if (rep_a)   begin n_rep[0]++;   at_rep[0]   = cyc; end
    if (press_b) begin n_press[1]++; at_press[1] = cyc; end
    if (rel_b)   begin n_rel[1]++;   at_rel[1]   = cyc; end
    if (long_b)  begin n_long[1]++;  at_long[1]  = cyc; end
    if (rep_b)   begin n_rep[1]++;   at_rep[1]   = cyc; end
    if (int'(press_a) + int'(rel_a) + int'(long_a) > 1) excl_bad++;
    if (int'(press_b) + int'(rel_b) + int'(long_b) > 1) excl_bad++;
  end

  task automatic edges(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic test_reset;
    edges(3);
    tests++;
    if ({pressed_a, press_a, rel_a, long_a, rep_a} !== 5'b0) begin
      fails++; $display("FAIL reset_a: got %b want 00000", {pressed_a, press_a, rel_a, long_a, rep_a});
    end
    tests++;
    if ({pressed_b, press_b, rel_b, long_b, rep_b} !== 5'b0) begin
      fails++; $display("FAIL reset_b: got %b want 00000", {pressed_b, press_b, rel_b, long_b, rep_b});
    end
    @(negedge CLK); RST_N = 1'b1;
    edges(8);
    tests++;
    if (n_press[0] + n_press[1] !== 0) begin
      fails++; $display("FAIL reset_idle_press: got %0d want 0", n_press[0] + n_press[1]);
    end
  endtask

  task automatic test_clean_press;
    int p0, r0, l0, t0, t1;
    p0 = n_press[0]; r0 = n_rel[0]; l0 = n_long[0];
    @(negedge CLK); but_a = 1'b1; t0 = cyc;
    edges(5);
    tests++;
    if (pressed_a !== 1'b0) begin fails++; $display("FAIL clean_pressed_early: got %b want 0", pressed_a); end
    edges(1);
    tests++;
    if ({pressed_a, press_a} !== 2'b11) begin
      fails++; $display("FAIL clean_press_edge6: got %b want 11", {pressed_a, press_a});
    end
    edges(4);
    tests++;
    if (n_press[0] - p0 !== 1 || at_press[0] !== t0 + 6) begin
      fails++; $display("FAIL clean_press_count: got n=%0d at=%0d want n=1 at=%0d", n_press[0] - p0, at_press[0], t0 + 6);
    end
    @(negedge CLK); but_a = 1'b0; t1 = cyc;
    edges(10);
    tests++;
    if (n_rel[0] - r0 !== 1 || at_rel[0] !== t1 + 6 || pressed_a !== 1'b0) begin
      fails++; $display("FAIL clean_release: got n=%0d at=%0d pressed=%b want n=1 at=%0d pressed=0", n_rel[0] - r0, at_rel[0], pressed_a, t1 + 6);
    end
    tests++;
    if (n_long[0] - l0 !== 0) begin fails++; $display("FAIL clean_no_long: got %0d want 0", n_long[0] - l0); end
  endtask

  task automatic test_bounce;
    int p0, r0, ts;
    p0 = n_press[0]; r0 = n_rel[0];
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK); but_a = (k % 2 == 0);
      repeat (2) @(negedge CLK);
    end
    edges(2);
    tests++;
    if (n_press[0] - p0 !== 0 || n_rel[0] - r0 !== 0 || pressed_a !== 1'b0) begin
      fails++; $display("FAIL bounce_quiet: got press=%0d rel=%0d pressed=%b want 0 0 0", n_press[0] - p0, n_rel[0] - r0, pressed_a);
    end
    @(negedge CLK); but_a = 1'b1; ts = cyc;
    edges(10);
    tests++;
    if (n_press[0] - p0 !== 1 || at_press[0] !== ts + 6) begin
      fails++; $display("FAIL bounce_settle_press: got n=%0d at=%0d want n=1 at=%0d", n_press[0] - p0, at_press[0], ts + 6);
    end
    @(negedge CLK); but_a = 1'b0;
    edges(10);
    tests++;
    if (n_rel[0] - r0 !== 1) begin fails++; $display("FAIL bounce_release: got %0d want 1", n_rel[0] - r0); end
  endtask

  task automatic test_long_press;
    int p0, r0, l0, t0, t1;
    p0 = n_press[0]; r0 = n_rel[0]; l0 = n_long[0];
    @(negedge CLK); but_a = 1'b1; t0 = cyc;
    edges(40);
    @(negedge CLK); but_a = 1'b0; t1 = cyc;
    edges(10);
    tests++;
    if (n_press[0] - p0 !== 1 || at_press[0] !== t0 + 6) begin
      fails++; $display("FAIL long_press_edge: got n=%0d at=%0d want n=1 at=%0d", n_press[0] - p0, at_press[0], t0 + 6);
    end
    tests++;
    if (n_long[0] - l0 !== 1 || at_long[0] !== t0 + 26) begin
      fails++; $display("FAIL long_fire: got n=%0d at=%0d want n=1 at=%0d", n_long[0] - l0, at_long[0], t0 + 26);
    end
    tests++;
    if (n_rel[0] - r0 !== 1 || at_rel[0] !== t1 + 6 || pressed_a !== 1'b0) begin
      fails++; $display("FAIL long_release: got n=%0d at=%0d pressed=%b want n=1 at=%0d pressed=0", n_rel[0] - r0, at_rel[0], pressed_a, t1 + 6);
    end
  endtask

  task automatic test_release_bounce;
    int p0, r0, l0, t0;
    bit dropped;
    p0 = n_press[0]; r0 = n_rel[0]; l0 = n_long[0]; dropped = 1'b0;
    @(negedge CLK); but_a = 1'b1; t0 = cyc;
    edges(8);
    @(negedge CLK); but_a = 1'b0;
    repeat (2) @(negedge CLK);
    but_a = 1'b1;
    for (int k = 0; k < 25; k++) begin
      edges(1);
      if (pressed_a !== 1'b1) dropped = 1'b1;
    end
    tests++;
    if (dropped) begin fails++; $display("FAIL relbounce_pressed: got dropout want steady 1"); end
    tests++;
    if (n_press[0] - p0 !== 1 || n_rel[0] - r0 !== 0) begin
      fails++; $display("FAIL relbounce_events: got press=%0d rel=%0d want 1 0", n_press[0] - p0, n_rel[0] - r0);
    end
    tests++;
    if (n_long[0] - l0 !== 1 || at_long[0] !== t0 + 28) begin
      fails++; $display("FAIL relbounce_long_shift: got n=%0d at=%0d want n=1 at=%0d", n_long[0] - l0, at_long[0], t0 + 28);
    end
    @(negedge CLK); but_a = 1'b0;
    edges(10);
    tests++;
    if (n_rel[0] - r0 !== 1) begin fails++; $display("FAIL relbounce_release: got %0d want 1", n_rel[0] - r0); end
  endtask

  task automatic test_reset_mid_press;
    int p0, r0, t1;
    @(negedge CLK); but_a = 1'b1;
    edges(30);
    tests++;
    if (pressed_a !== 1'b1) begin fails++; $display("FAIL midreset_pre: got pressed=%b want 1", pressed_a); end
    #3 RST_N = 1'b0;
    #1;
    tests++;
    if ({pressed_a, press_a, rel_a, long_a, rep_a} !== 5'b0) begin
      fails++; $display("FAIL midreset_async: got %b want 00000", {pressed_a, press_a, rel_a, long_a, rep_a});
    end
    p0 = n_press[0]; r0 = n_rel[0];
    edges(3);
    @(negedge CLK); RST_N = 1'b1; t1 = cyc;
    edges(10);
    tests++;
    if (n_press[0] - p0 !== 1 || at_press[0] !== t1 + 6 || n_rel[0] - r0 !== 0) begin
      fails++; $display("FAIL midreset_repress: got n=%0d at=%0d rel=%0d want n=1 at=%0d rel=0", n_press[0] - p0, at_press[0], n_rel[0] - r0, t1 + 6);
    end
    @(negedge CLK); but_a = 1'b0;
    edges(10);
  endtask

  task automatic test_active_low_repeat;
    int p0, r0, l0, q0, t0, t1, exp_n, exp_at;
    p0 = n_press[1]; r0 = n_rel[1]; l0 = n_long[1]; q0 = n_rep[1];
    @(negedge CLK); but_b = 1'b0; t0 = cyc;
    edges(40);
    tests++;
    if (n_press[1] - p0 !== 1 || at_press[1] !== t0 + 6 || pressed_b !== 1'b1) begin
      fails++; $display("FAIL al_press: got n=%0d at=%0d pressed=%b want n=1 at=%0d pressed=1", n_press[1] - p0, at_press[1], pressed_b, t0 + 6);
    end
    tests++;
    if (n_long[1] - l0 !== 1 || at_long[1] !== t0 + 26) begin
      fails++; $display("FAIL al_long: got n=%0d at=%0d want n=1 at=%0d", n_long[1] - l0, at_long[1], t0 + 26);
    end
    @(negedge CLK); but_b = 1'b1; t1 = cyc;
    edges(12);
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
    exp_n = 3; exp_at = t0 + 41;
`else
    exp_n = 0; exp_at = at_rep[1];
`endif
    tests++;
    if (n_rep[1] - q0 !== exp_n || at_rep[1] !== exp_at) begin
      fails++; $display("FAIL al_repeat: got n=%0d last=%0d want n=%0d last=%0d", n_rep[1] - q0, at_rep[1], exp_n, exp_at);
    end
    tests++;
    if (n_rel[1] - r0 !== 1 || at_rel[1] !== t1 + 6 || pressed_b !== 1'b0) begin
      fails++; $display("FAIL al_release: got n=%0d at=%0d pressed=%b want n=1 at=%0d pressed=0", n_rel[1] - r0, at_rel[1], pressed_b, t1 + 6);
    end
  endtask

  task automatic test_global;
    tests++;
    if (excl_bad !== 0) begin fails++; $display("FAIL exclusive_pulses: got %0d overlaps want 0", excl_bad); end
    tests++;
    if (n_rep[0] !== 0) begin fails++; $display("FAIL no_repeat_a: got %0d want 0", n_rep[0]); end
  endtask

  initial begin
    test_reset;
    test_clean_press;
    test_bounce;
    test_long_press;
    test_release_bounce;
    test_reset_mid_press;
    test_active_low_repeat;
    test_global;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
